chipper_ejector: RTL and testbench

- Ejection stage of the CHIPPER bufferless deflection router; the counterpart of the injector.
- Each cycle it examines the four incoming link flits (north, south, east, west) and removes at most one flit whose destination equals this node.
- The removed flit goes into a small ejection FIFO, which the local core drains with a valid/ready handshake.
- All other flits, including any local flit not ejected, pass through one register stage to the injector/permutation network.

---
 rtl/chipper_ejector.sv | 168 ++++++++++++++++
 tb/tb_chipper_ejector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chipper_ejector.sv
// CHIPPER ejection stage: pulls at most one locally addressed flit per cycle
// out of the four link inputs into a small FIFO, and registers everything
// else through to the injector stage.
module chipper_ejector #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int EJ_DEPTH = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] node_id,
  input  logic              in_n_vld,
  input  logic              in_s_vld,
  input  logic              in_e_vld,
  input  logic              in_w_vld,
  input  logic [ADDR_W-1:0] in_n_addr,
  input  logic [ADDR_W-1:0] in_s_addr,
  input  logic [ADDR_W-1:0] in_e_addr,
  input  logic [ADDR_W-1:0] in_w_addr,
  input  logic [DATA_W-1:0] in_n_data,
  input  logic [DATA_W-1:0] in_s_data,
  input  logic [DATA_W-1:0] in_e_data,
  input  logic [DATA_W-1:0] in_w_data,
  output logic              out_n_vld,
  output logic              out_s_vld,
  output logic              out_e_vld,
  output logic              out_w_vld,
  output logic [ADDR_W-1:0] out_n_addr,
  output logic [ADDR_W-1:0] out_s_addr,
  output logic [ADDR_W-1:0] out_e_addr,
  output logic [ADDR_W-1:0] out_w_addr,
  output logic [DATA_W-1:0] out_n_data,
  output logic [DATA_W-1:0] out_s_data,
  output logic [DATA_W-1:0] out_e_data,
  output logic [DATA_W-1:0] out_w_data,
  output logic              ej_vld,
  output logic [ADDR_W-1:0] ej_addr,
  output logic [DATA_W-1:0] ej_data,
  input  logic              ej_rdy,
  output logic [CNT_W-1:0]  ej_count,
  output logic              ej_full
);

  localparam int PTR_W = (EJ_DEPTH > 1) ? $clog2(EJ_DEPTH) : 1;

  // Port index order N=0, S=1, E=2, W=3 everywhere below.
  logic [3:0]              in_vld;
  logic [3:0][ADDR_W-1:0]  in_addr;
  logic [3:0][DATA_W-1:0]  in_data;
  logic [3:0]              out_vld_q;
  logic [3:0][ADDR_W-1:0]  out_addr_q;
  logic [3:0][DATA_W-1:0]  out_data_q;

  assign in_vld  = {in_w_vld, in_e_vld, in_s_vld, in_n_vld};
  assign in_addr = {in_w_addr, in_e_addr, in_s_addr, in_n_addr};
  assign in_data = {in_w_data, in_e_data, in_s_data, in_n_data};

  assign out_n_vld  = out_vld_q[0];
  assign out_s_vld  = out_vld_q[1];
  assign out_e_vld  = out_vld_q[2];
  assign out_w_vld  = out_vld_q[3];
  assign out_n_addr = out_addr_q[0];
  assign out_s_addr = out_addr_q[1];
  assign out_e_addr = out_addr_q[2];
  assign out_w_addr = out_addr_q[3];
  assign out_n_data = out_data_q[0];
  assign out_s_data = out_data_q[1];
  assign out_e_data = out_data_q[2];
  assign out_w_data = out_data_q[3];

  logic [1:0]       rr;
  logic [3:0]       cand;
  logic [3:0]       gnt;
  logic [1:0]       gnt_idx;
  logic [1:0]       idx;
  logic             gnt_any;
  logic             eject_en;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] mem_addr [EJ_DEPTH];
  logic [DATA_W-1:0] mem_data [EJ_DEPTH];

  // Eject enable uses registered occupancy only, so a same-cycle pop never
  // makes room for a push and ej_rdy stays off every combinational path.
  assign eject_en = !ej_full;

  // Per-port local-destination detection.
  always_comb begin
    cand = '0;
    for (int p = 0; p < 4; p++) begin
      cand[p] = in_vld[p] && (in_addr[p] == node_id);
    end
  end

  // Round-robin search starting at rr; first candidate wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = rr;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr + 2'(k);
      if (!gnt_any && eject_en && cand[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign push = gnt_any;
  assign pop  = ej_vld && ej_rdy;

  // Arbitration pointer moves just past the winner; holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 2'd0;
    end else if (gnt_any) begin
      rr <= gnt_idx + 2'd1;
    end
  end

  // Pass-through stage; a local flit that was not granted is deflected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        out_vld_q[p]  <= in_vld[p] && !gnt[p];
        out_addr_q[p] <= in_addr[p];
        out_data_q[p] <= in_data[p];
      end
    end
  end

  // FIFO pointers and occupancy; power-of-two depth gives natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ej_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      ej_count <= ej_count + CNT_W'(1);
      else if (pop && !push) ej_count <= ej_count - CNT_W'(1);
    end
  end

  // FIFO storage; contents are don't-care while empty, head output is masked.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_addr[gnt_idx];
      mem_data[wr_ptr] <= in_data[gnt_idx];
    end
  end

  assign ej_vld  = (ej_count != '0);
  assign ej_full = (ej_count == CNT_W'(EJ_DEPTH));
  assign ej_addr = ej_vld ? mem_addr[rd_ptr] : '0;
  assign ej_data = ej_vld ? mem_data[rd_ptr] : '0;

endmodule

// File: tb/tb_chipper_ejector.sv
// Bench for chipper_ejector: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the ejector.
module tb_chipper_ejector;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst_n;
  logic [AW-1:0]     node_id;
  logic [3:0]        t_vld;
  logic [3:0][AW-1:0] t_addr;
  logic [3:0][DW-1:0] t_data;
  logic [3:0]        o_vld;
  logic [3:0][AW-1:0] o_addr;
  logic [3:0][DW-1:0] o_data;
  logic              ej_vld;
  logic [AW-1:0]     ej_addr;
  logic [DW-1:0]     ej_data;
  logic              ej_rdy;
  logic [2:0]        ej_count;
  logic              ej_full;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } flit_t;

  flit_t              q[$];
  int                 m_rr;
  logic [3:0]         e_vld;
  logic [3:0][AW-1:0] e_addr;
  logic [3:0][DW-1:0] e_data;

  chipper_ejector dut (
    .clk(clk), .rst_n(rst_n), .node_id(node_id),
    .in_n_vld(t_vld[0]), .in_s_vld(t_vld[1]), .in_e_vld(t_vld[2]), .in_w_vld(t_vld[3]),
    .in_n_addr(t_addr[0]), .in_s_addr(t_addr[1]), .in_e_addr(t_addr[2]), .in_w_addr(t_addr[3]),
    .in_n_data(t_data[0]), .in_s_data(t_data[1]), .in_e_data(t_data[2]), .in_w_data(t_data[3]),
    .out_n_vld(o_vld[0]), .out_s_vld(o_vld[1]), .out_e_vld(o_vld[2]), .out_w_vld(o_vld[3]),
    .out_n_addr(o_addr[0]), .out_s_addr(o_addr[1]), .out_e_addr(o_addr[2]), .out_w_addr(o_addr[3]),
    .out_n_data(o_data[0]), .out_s_data(o_data[1]), .out_e_data(o_data[2]), .out_w_data(o_data[3]),
    .ej_vld(ej_vld), .ej_addr(ej_addr), .ej_data(ej_data), .ej_rdy(ej_rdy),
    .ej_count(ej_count), .ej_full(ej_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    q.delete();
    m_rr   = 0;
    e_vld  = '0;
    e_addr = '0;
    e_data = '0;
  endtask

  // One cycle of the reference: pop decided on pre-edge occupancy, at most one
  // grant by rotating priority when not full, everything else passes through.
  task automatic model_step();
    bit pop;
    int g;
    pop = (q.size() != 0) && ej_rdy;
    g = -1;
    if (q.size() < DEPTH) begin
      for (int k = 0; k < 4; k++) begin
        int p;
        p = (m_rr + k) % 4;
        if (g < 0 && t_vld[p] && t_addr[p] == node_id) g = p;
      end
    end
    if (pop) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back({t_addr[g], t_data[g]});
      m_rr = (g + 1) % 4;
    end
    for (int p = 0; p < 4; p++) begin
      e_vld[p]  = t_vld[p] && (p != g);
      e_addr[p] = t_addr[p];
      e_data[p] = t_data[p];
    end
  endtask

  task automatic apply();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    t_vld  = '0;
    t_addr = '0;
    t_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (ej_vld !== 1'b0) begin n_err++; $display("FAIL reset_ej_vld: got %b want 0", ej_vld); end
    n_vec++; if (ej_count !== 3'd0) begin n_err++; $display("FAIL reset_ej_count: got %0d want 0", ej_count); end
    n_vec++; if (ej_full !== 1'b0) begin n_err++; $display("FAIL reset_ej_full: got %b want 0", ej_full); end
    n_vec++; if (o_vld !== 4'b0000) begin n_err++; $display("FAIL reset_out_vld: got %b want 0000", o_vld); end
    n_vec++; if (ej_data !== 32'h0) begin n_err++; $display("FAIL reset_ej_data: got %h want 0", ej_data); end
    n_vec++; if (o_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", o_data); end
  endtask

  task automatic test_single();
    do_reset();
    ej_rdy = 1'b1;
    t_vld[1] = 1'b1; t_addr[1] = 6'b000101; t_data[1] = 32'hA5A5_0001;
    apply();
    idle_inputs();
    n_vec++; if (o_vld[1] !== 1'b0) begin n_err++; $display("FAIL single_out_s_vld: got %b want 0", o_vld[1]); end
    n_vec++; if (ej_vld !== 1'b1) begin n_err++; $display("FAIL single_ej_vld: got %b want 1", ej_vld); end
    n_vec++; if (ej_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_ej_data: got %h want a5a50001", ej_data); end
    n_vec++; if (ej_addr !== 6'b000101) begin n_err++; $display("FAIL single_ej_addr: got %b want 000101", ej_addr); end
    n_vec++; if (ej_count !== 3'd1) begin n_err++; $display("FAIL single_count1: got %0d want 1", ej_count); end
    apply();
    n_vec++; if (ej_count !== 3'd0) begin n_err++; $display("FAIL single_count0: got %0d want 0", ej_count); end
  endtask

  task automatic test_four();
    logic [3:0] want_vld [3];
    logic [31:0] want_data [3];
    want_vld[0] = 4'b1110; want_vld[1] = 4'b1101; want_vld[2] = 4'b1011;
    want_data[0] = 32'h11; want_data[1] = 32'h22; want_data[2] = 32'h33;
    do_reset();
    ej_rdy = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 4; p++) begin
        t_vld[p] = 1'b1; t_addr[p] = node_id; t_data[p] = 32'(p + 1) * 32'h11;
      end
      apply();
      n_vec++; if (o_vld !== want_vld[r]) begin n_err++; $display("FAIL four_out_vld[%0d]: got %b want %b", r, o_vld, want_vld[r]); end
      n_vec++; if (ej_data !== want_data[r]) begin n_err++; $display("FAIL four_ej_data[%0d]: got %h want %h", r, ej_data, want_data[r]); end
    end
    idle_inputs();
    apply();
  endtask

  task automatic test_mixed();
    do_reset();
    ej_rdy = 1'b1;
    t_vld[0] = 1'b1; t_addr[0] = 6'b100101; t_data[0] = 32'h1111_1111;
    t_vld[2] = 1'b1; t_addr[2] = 6'b000101; t_data[2] = 32'h3333_3333;
    apply();
    idle_inputs();
    n_vec++; if (o_vld !== 4'b0001) begin n_err++; $display("FAIL mixed_out_vld: got %b want 0001", o_vld); end
    n_vec++; if (o_addr[0] !== 6'b100101) begin n_err++; $display("FAIL mixed_out_n_addr: got %b want 100101", o_addr[0]); end
    n_vec++; if (ej_data !== 32'h3333_3333) begin n_err++; $display("FAIL mixed_ej_data: got %h want 33333333", ej_data); end
    apply();
  endtask

  task automatic test_full();
    do_reset();
    ej_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      t_vld[0] = 1'b1; t_addr[0] = node_id; t_data[0] = 32'(i);
      apply();
      n_vec++; if (o_vld[0] !== (i == 5)) begin n_err++; $display("FAIL full_out_n_vld[%0d]: got %b want %b", i, o_vld[0], (i == 5)); end
      n_vec++; if (ej_full !== (i >= 4)) begin n_err++; $display("FAIL full_flag[%0d]: got %b want %b", i, ej_full, (i >= 4)); end
    end
    idle_inputs();
    ej_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_vec++; if (ej_data !== 32'(i)) begin n_err++; $display("FAIL full_drain[%0d]: got %h want %h", i, ej_data, 32'(i)); end
      apply();
    end
    n_vec++; if (ej_vld !== 1'b0) begin n_err++; $display("FAIL full_drained_vld: got %b want 0", ej_vld); end
  endtask

  task automatic test_push_pop();
    do_reset();
    ej_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      t_vld[0] = 1'b1; t_addr[0] = node_id; t_data[0] = 32'(100 + i);
      apply();
    end
    ej_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      t_data[0] = 32'(102 + i);
      n_vec++; if (ej_data !== 32'(100 + i)) begin n_err++; $display("FAIL pp_head[%0d]: got %0d want %0d", i, ej_data, 100 + i); end
      apply();
      n_vec++; if (ej_count !== 3'd2) begin n_err++; $display("FAIL pp_count[%0d]: got %0d want 2", i, ej_count); end
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (ej_data !== 32'(110 + i)) begin n_err++; $display("FAIL pp_tail[%0d]: got %0d want %0d", i, ej_data, 110 + i); end
      apply();
    end
    n_vec++; if (ej_vld !== 1'b0) begin n_err++; $display("FAIL pp_empty: got %b want 0", ej_vld); end
  endtask

  task automatic test_async_reset();
    do_reset();
    ej_rdy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      t_vld[0] = 1'b1; t_addr[0] = node_id; t_data[0] = 32'(i);
      t_vld[1] = 1'b1; t_addr[1] = 6'h3F;   t_data[1] = 32'hBEEF;
      apply();
    end
    n_vec++; if (ej_count !== 3'd3) begin n_err++; $display("FAIL arst_pre_count: got %0d want 3", ej_count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (ej_vld !== 1'b0) begin n_err++; $display("FAIL arst_ej_vld: got %b want 0", ej_vld); end
    n_vec++; if (ej_count !== 3'd0) begin n_err++; $display("FAIL arst_ej_count: got %0d want 0", ej_count); end
    n_vec++; if (o_vld !== 4'b0000) begin n_err++; $display("FAIL arst_out_vld: got %b want 0000", o_vld); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    ej_rdy = 1'b1;
    for (int p = 0; p < 4; p++) begin
      t_vld[p] = 1'b1; t_addr[p] = node_id; t_data[p] = 32'hC0 + 32'(p);
    end
    apply();
    idle_inputs();
    n_vec++; if (ej_data !== 32'hC0) begin n_err++; $display("FAIL arst_first_grant: got %h want c0", ej_data); end
    n_vec++; if (o_vld !== 4'b1110) begin n_err++; $display("FAIL arst_out_vld_after: got %b want 1110", o_vld); end
    apply();
  endtask

  task automatic test_random();
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_data;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 4; p++) begin
        t_vld[p]  = 1'($urandom_range(0, 1));
        t_addr[p] = ($urandom_range(0, 2) != 0) ? node_id : AW'($urandom);
        t_data[p] = $urandom;
      end
      ej_rdy = ($urandom_range(0, 2) == 0);
      apply();
      x_addr = (q.size() != 0) ? q[0].a : '0;
      x_data = (q.size() != 0) ? q[0].d : '0;
      n_vec++; if (o_vld !== e_vld) begin n_err++; $display("FAIL rnd_out_vld@%0d: got %b want %b", c, o_vld, e_vld); end
      n_vec++; if (o_addr !== e_addr) begin n_err++; $display("FAIL rnd_out_addr@%0d: got %h want %h", c, o_addr, e_addr); end
      n_vec++; if (o_data !== e_data) begin n_err++; $display("FAIL rnd_out_data@%0d: got %h want %h", c, o_data, e_data); end
      n_vec++; if (ej_count !== 3'(q.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, ej_count, q.size()); end
      n_vec++; if (ej_vld !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_ej_vld@%0d: got %b want %b", c, ej_vld, (q.size() != 0)); end
      n_vec++; if (ej_full !== (q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full@%0d: got %b want %b", c, ej_full, (q.size() == DEPTH)); end
      n_vec++; if (ej_addr !== x_addr) begin n_err++; $display("FAIL rnd_ej_addr@%0d: got %h want %h", c, ej_addr, x_addr); end
      n_vec++; if (ej_data !== x_data) begin n_err++; $display("FAIL rnd_ej_data@%0d: got %h want %h", c, ej_data, x_data); end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n   = 1'b0;
    node_id = 6'b000101;
    ej_rdy  = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    test_reset();
    test_single();
    test_four();
    test_mixed();
    test_full();
    test_push_pop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
